// File: rtl/wave_fb_pkg.sv
// Shared types and constants for the waveform framebuffer writer.
// Holds the screen geometry, the FSM state type, the FIFO entry layout and the address helper.
package wave_fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FB_ADDR_W = 19;
    localparam int FB_PIXELS = H_RES_DEF * V_RES_DEF;
    localparam int COORD_W   = 11;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_WAIT,
        CLEAR
    } wr_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic                 data;
    } fb_entry_t;

    // Row-major linear address; all terms are widened to 19 bits before the multiply.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int                 h_res
    );
        return FB_ADDR_W'(y) * FB_ADDR_W'(h_res) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/wave_pixel_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry.
// A push into a full FIFO only lands when a pop happens on the same edge.
module wave_pixel_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wave_pixel_writer.sv
// Turns the line drawer's free-running (x, y, colour) stream into framebuffer writes,
// with a full-frame clear engine sharing the same valid/ready write port.
module wave_pixel_writer
    import wave_fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [COORD_W-1:0]          x_in,
    input  logic [COORD_W-1:0]          y_in,
    input  logic                        pixel_color_in,
    input  logic                        clear_req,
    input  logic                        fb_ready,
    output logic                        fb_wr,
    output logic [FB_ADDR_W-1:0]        fb_addr,
    output logic                        fb_data,
    output logic                        clear_busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam logic [COORD_W-1:0]   X_LIM     = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0]   Y_LIM     = COORD_W'(V_RES);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_RES * V_RES - 1);

    wr_state_t            state;
    wr_state_t            state_next;
    logic [COORD_W-1:0]   x_p0;
    logic [COORD_W-1:0]   y_p0;
    logic                 c_p0;
    logic                 prev_valid;
    logic                 vld_p0;
    logic                 tuple_new;
    logic                 on_screen;
    logic                 capture;
    logic                 clearing;
    logic                 wr_valid;
    logic                 transfer;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 last_clear;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ovf;
    logic [FB_ADDR_W-1:0] clr_addr;
    fb_entry_t            push_entry;
    fb_entry_t            head;

    assign tuple_new  = !prev_valid || (x_in != x_p0) || (y_in != y_p0) || (pixel_color_in != c_p0);
    assign on_screen  = (x_in < X_LIM) && (y_in < Y_LIM);
    assign capture    = (state == IDLE) && tuple_new;
    assign clearing   = (state == CLEAR);
    assign wr_valid   = clearing || !fifo_empty;
    assign transfer   = wr_valid && fb_ready;
    assign pop        = transfer && !clearing;
    assign push       = vld_p0 && !clearing;
    assign last_clear = clearing && transfer && (clr_addr == LAST_ADDR);

    // Stage 0: the captured tuple doubles as the last-seen tuple for change detection.
    always_ff @(posedge clk) begin
        if (capture) begin
            x_p0 <= x_in;
            y_p0 <= y_in;
            c_p0 <= pixel_color_in;
        end
    end

    // Stage 1: address formed from the captured tuple and pushed on the following edge.
    assign push_entry.addr = pixel_addr(x_p0, y_p0, H_RES);
    assign push_entry.data = c_p0;

    wave_pixel_fifo #(
        .DATA_W ($bits(fb_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR_WAIT;
                end
            end
            CLEAR_WAIT: begin
                // Let a presented write finish so the handshake is never withdrawn.
                if (!wr_valid || transfer) begin
                    state_next = CLEAR;
                    flush      = 1'b1;
                end
            end
            CLEAR: begin
                if (last_clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            prev_valid <= 1'b0;
            ovf        <= 1'b0;
            clr_addr   <= '0;
        end else begin
            vld_p0 <= capture && on_screen;
            if (capture) begin
                prev_valid <= 1'b1;
            end else if (last_clear) begin
                prev_valid <= 1'b0;
            end
            if (flush) begin
                ovf <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
            if (flush) begin
                clr_addr <= '0;
            end else if (clearing && transfer) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    assign fb_wr      = wr_valid;
    assign fb_addr    = clearing ? clr_addr : (fifo_empty ? '0 : head.addr);
    assign fb_data    = !clearing && !fifo_empty && head.data;
    assign clear_busy = (state != IDLE);
    assign overflow   = ovf;

endmodule

// File: tb/tb_wave_pixel_writer.sv
// Scoreboard bench for wave_pixel_writer: expected writes are queued as stimulus is
// driven and retired by a monitor at each handshake.
module tb_wave_pixel_writer;

    localparam int TB_H = 640;
    localparam int TB_V = 32;
    localparam int PIX  = TB_H * TB_V;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x_in = 11'd700;
    logic [10:0] y_in = 11'd0;
    logic        pixel_color_in = 1'b0;
    logic        clear_req = 1'b0;
    logic        fb_ready = 1'b0;
    logic        fb_wr;
    logic [18:0] fb_addr;
    logic        fb_data;
    logic        clear_busy;
    logic        overflow;
    logic [4:0]  fifo_level;

    logic        d2_clear = 1'b0;
    logic        d2_ready = 1'b1;
    logic        d2_wr;
    logic [18:0] d2_addr;
    logic        d2_data;
    logic        d2_busy;
    logic        d2_ovf;
    logic [4:0]  d2_level;

    int          vectors = 0;
    int          miscompares = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_e;
    logic        held = 1'b0;
    logic [18:0] held_addr;
    logic        held_data;

    always #5 clk = ~clk;

    wave_pixel_writer #(.H_RES(TB_H), .V_RES(TB_V), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .pixel_color_in(pixel_color_in),
        .clear_req(clear_req), .fb_ready(fb_ready), .fb_wr(fb_wr), .fb_addr(fb_addr),
        .fb_data(fb_data), .clear_busy(clear_busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    wave_pixel_writer dut_full (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .pixel_color_in(pixel_color_in),
        .clear_req(d2_clear), .fb_ready(d2_ready), .fb_wr(d2_wr), .fb_addr(d2_addr),
        .fb_data(d2_data), .clear_busy(d2_busy), .overflow(d2_ovf), .fifo_level(d2_level)
    );

    function automatic logic [19:0] ent(input int x, input int y, input logic c);
        logic [18:0] a;
        a = 19'(y * TB_H + x);
        return {a, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic c);
        x_in = 11'(x);
        y_in = 11'(y);
        pixel_color_in = c;
    endtask

    // Retire one expected write per handshake and police the hold-until-transfer rule.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                vectors++;
                if (!fb_wr || fb_addr !== held_addr || fb_data !== held_data) begin
                    miscompares++;
                    $display("FAIL hold: wr=%0b addr=%0d data=%0b required wr=1 addr=%0d data=%0b",
                             fb_wr, fb_addr, fb_data, held_addr, held_data);
                end
            end
            if (fb_wr && fb_ready) begin
                vectors++;
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write: unexpected addr=%0d data=%0b", fb_addr, fb_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({fb_addr, fb_data} !== exp_e) begin
                        miscompares++;
                        $display("FAIL write: addr=%0d data=%0b required addr=%0d data=%0b",
                                 fb_addr, fb_data, exp_e[19:1], exp_e[0]);
                    end
                end
            end else if (fb_wr) begin
                held = 1'b1;
                held_addr = fb_addr;
                held_data = fb_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if (fb_wr !== 1'b0 || fb_addr !== 19'd0 || fb_data !== 1'b0 ||
            clear_busy !== 1'b0 || overflow !== 1'b0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL %s: wr=%0b addr=%0d data=%0b busy=%0b ovf=%0b lvl=%0d required all 0",
                     tag, fb_wr, fb_addr, fb_data, clear_busy, overflow, fifo_level);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(700, 0, 1'b0);
        tick();
        tick();
        check_idle_outputs("reset_state");
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (fb_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL offscreen_after_reset: fb_wr=%0b required 0", fb_wr);
        end
    endtask

    task automatic test_single_tuple();
        fb_ready = 1'b1;
        drive(10, 2, 1'b1);
        exp_q.push_back(ent(10, 2, 1'b1));
        tick();
        vectors++;
        if (fb_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL single_e0: fb_wr=%0b required 0", fb_wr);
        end
        tick();
        vectors++;
        if (fb_wr !== 1'b1 || fb_addr !== 19'd1290 || fb_data !== 1'b1 || fifo_level !== 5'd1) begin
            miscompares++;
            $display("FAIL single_e1: wr=%0b addr=%0d data=%0b lvl=%0d required 1 1290 1 1",
                     fb_wr, fb_addr, fb_data, fifo_level);
        end
        repeat (4) tick();
        vectors++;
        if (fb_wr !== 1'b0 || fifo_level !== 5'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_held: wr=%0b lvl=%0d pending=%0d required 0 0 0",
                     fb_wr, fifo_level, exp_q.size());
        end
    endtask

    task automatic test_offscreen();
        drive(640, 0, 1'b1);
        tick();
        drive(0, 480, 1'b1);
        tick();
        drive(0, TB_V, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (fb_wr !== 1'b0 || fifo_level !== 5'd0) begin
                miscompares++;
                $display("FAIL offscreen: wr=%0b lvl=%0d required 0 0", fb_wr, fifo_level);
            end
        end
    endtask

    task automatic test_back_to_back();
        fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(200 + i, 10 + i, ~i[0]);
            exp_q.push_back(ent(200 + i, 10 + i, ~i[0]));
            tick();
            vectors++;
            if (fifo_level > 5'd1) begin
                miscompares++;
                $display("FAIL b2b_level: lvl=%0d required <=1", fifo_level);
            end
        end
        repeat (3) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int n;
        fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(100 + i, 5, i[0]);
            if (i < 16) exp_q.push_back(ent(100 + i, 5, i[0]));
            tick();
        end
        tick();
        vectors++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1 || fb_wr !== 1'b1 ||
            fb_addr !== 19'd3300 || fb_data !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full: lvl=%0d ovf=%0b wr=%0b addr=%0d data=%0b required 16 1 1 3300 0",
                     fifo_level, overflow, fb_wr, fb_addr, fb_data);
        end
        fb_ready = 1'b1;
        n = 0;
        while (fifo_level != 5'd0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (exp_q.size() != 0 || n != 16 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain: pending=%0d cycles=%0d ovf=%0b required 0 16 1",
                     exp_q.size(), n, overflow);
        end
    endtask

    task automatic test_clear();
        int n;
        fb_ready = 1'b1;
        drive(7, 3, 1'b1);
        exp_q.push_back(ent(7, 3, 1'b1));
        repeat (4) tick();
        for (int a = 0; a < PIX; a++) exp_q.push_back({19'(a), 1'b0});
        exp_q.push_back(ent(7, 3, 1'b1));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 1;
        vectors++;
        if (clear_busy !== 1'b1 || fb_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_wait: busy=%0b wr=%0b required 1 0", clear_busy, fb_wr);
        end
        tick();
        n = 2;
        vectors++;
        if (fb_wr !== 1'b1 || fb_addr !== 19'd0 || fb_data !== 1'b0 || overflow !== 1'b0 || clear_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_start: wr=%0b addr=%0d data=%0b ovf=%0b busy=%0b required 1 0 0 0 1",
                     fb_wr, fb_addr, fb_data, overflow, clear_busy);
        end
        while (clear_busy && n < PIX + 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n != PIX + 2) begin
            miscompares++;
            $display("FAIL clear_length: busy fell after %0d edges required %0d", n, PIX + 2);
        end
        repeat (4) tick();
        vectors++;
        if (exp_q.size() != 0 || fb_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_rewrite: pending=%0d wr=%0b required 0 0", exp_q.size(), fb_wr);
        end
    endtask

    task automatic test_clear_pending_reset();
        int n;
        fb_ready = 1'b0;
        drive(20, 1, 1'b1);
        exp_q.push_back(ent(20, 1, 1'b1));
        tick();
        drive(21, 1, 1'b0);
        tick();
        drive(22, 1, 1'b1);
        tick();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        vectors++;
        if (clear_busy !== 1'b1 || fb_wr !== 1'b1 || fb_addr !== 19'd660 || fifo_level !== 5'd3) begin
            miscompares++;
            $display("FAIL pend_wait: busy=%0b wr=%0b addr=%0d lvl=%0d required 1 1 660 3",
                     clear_busy, fb_wr, fb_addr, fifo_level);
        end
        tick();
        for (int a = 0; a < PIX; a++) exp_q.push_back({19'(a), 1'b0});
        fb_ready = 1'b1;
        tick();
        vectors++;
        if (fb_wr !== 1'b1 || fb_addr !== 19'd0 || fb_data !== 1'b0 || fifo_level !== 5'd0 || clear_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_clear: wr=%0b addr=%0d data=%0b lvl=%0d busy=%0b required 1 0 0 0 1",
                     fb_wr, fb_addr, fb_data, fifo_level, clear_busy);
        end
        n = 0;
        while (fb_addr != 19'd1000 && n < 1200) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 1000) begin
            miscompares++;
            $display("FAIL pend_progress: addr 1000 after %0d edges required 1000", n);
        end
        reset = 1'b1;
        drive(700, 0, 1'b0);
        tick();
        check_idle_outputs("reset_mid_clear");
        exp_q.delete();
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("after_reset_mid_clear");
    endtask

    task automatic test_max_addr();
        drive(639, 479, 1'b1);
        tick();
        tick();
        vectors++;
        if (d2_wr !== 1'b1 || d2_addr !== 19'd307199 || d2_data !== 1'b1) begin
            miscompares++;
            $display("FAIL max_addr: wr=%0b addr=%0d data=%0b required 1 307199 1", d2_wr, d2_addr, d2_data);
        end
        vectors++;
        if (fb_wr !== 1'b0 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL short_frame_offscreen: wr=%0b lvl=%0d required 0 0", fb_wr, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_tuple();
        test_offscreen();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_clear_pending_reset();
        test_max_addr();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: pending=%0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wave_pixel_writer.md
# wave_pixel_writer

Downstream consumer of the waveform line drawer. It turns the drawer's free-running (x, y, pixel_color) outputs into discrete framebuffer write transactions. Only changed tuples that fall on-screen are kept; they are buffered in a small FIFO and written one at a time over a valid/ready handshake. A full-screen clear engine shares the same write port.

## Interface
- H_RES, 640, visible columns; x ≥ H_RES is off-screen
- V_RES, 480, visible rows; y ≥ V_RES is off-screen
- FIFO_DEPTH, 16, pending-write entries (power of two, ≥ 4)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- x_in  in  11  drawer column
- y_in  in  11  drawer row
- pixel_color_in  in  1  drawer colour (1 = lit)
- clear_req  in  1  single-cycle request to blank the whole frame
- fb_ready  in  1  framebuffer accepts the write this cycle
- fb_wr  out  1  write valid
- fb_addr  out  19  y*H_RES + x
- fb_data  out  1  pixel value
- clear_busy  out  1  clear pending or in progress
- overflow  out  1  sticky: a tuple was dropped on a full FIFO
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- **Capture.** On each edge in IDLE, the input tuple is captured when it differs from the last captured tuple or when prev_valid = 0. Off-screen tuples are discarded but still update the last-captured tuple.
- **Stage 2.** Computes addr = y*H_RES + x, with an unsigned 19-bit result and no truncation (max 307199), then pushes {addr, colour} into the FIFO.
- **Push to full FIFO.** The tuple is dropped and overflow is set. If a pop happens on the same edge, the push succeeds.
- **Output.** fb_wr = FIFO non-empty (or clear engine active). fb_addr and fb_data come straight from the FIFO head, which is show-ahead. A transfer happens on an edge where fb_wr & fb_ready.
- **Stability rule.** Once fb_wr is high, fb_wr, fb_addr and fb_data hold unchanged until the transfer.
- **FSM states.**
  - **IDLE.** Normal capture.
  - **CLEAR_WAIT.** Entered when clear_req is seen in IDLE. Capture stops. The FSM stays here until no write is outstanding: fb_wr is low, or a transfer happens this edge. The FIFO is then flushed and the FSM goes to CLEAR.
  - **CLEAR.** Emits addresses 0 … H_RES*V_RES-1 with fb_data = 0, one per transfer. After the transfer of the last address, the FSM returns to IDLE and clears prev_valid, so the current drawer pixel is re-written.
- **Clear flag behaviour.** clear_req outside IDLE is ignored. clear_busy is high in CLEAR_WAIT and CLEAR. Entering CLEAR also clears overflow.
- **FIFO drops.** Tuples sitting in the FIFO when CLEAR_WAIT exits are discarded without being written.
- **Reset, including mid-clear or mid-handshake.** State → IDLE, FIFO empty, prev_valid = 0, and all outputs 0 on the next cycle: fb_wr, fb_addr, fb_data, clear_busy, overflow, fifo_level. An outstanding write is abandoned.

## Timing
- Tuple changes before edge E0: captured at E0, pushed at E1. fb_wr is high after E1, so the earliest transfer is at E2. Each tuple takes 2 edges from capture to first possible transfer.
- Throughput is one write per cycle while fb_ready stays high. fifo_level updates on the edge of the push or pop.
- clear_req at edge C with nothing outstanding:
  - CLEAR_WAIT after C.
  - CLEAR after C+1, with fb_wr high and fb_addr = 0.
  - A full clear takes 307200 transfers. IDLE follows the edge of the last transfer.
- Simultaneous push and pop leaves fifo_level unchanged.

## Structure
- **Package wave_fb_pkg.**
  - H_RES and V_RES defaults.
  - FB_ADDR_W = 19 and FB_PIXELS = H_RES*V_RES.
  - State enum {IDLE, CLEAR_WAIT, CLEAR}.
  - Typedef for the FIFO entry {addr, data}.
- **Sub-module wave_pixel_fifo.** Synchronous show-ahead FIFO with push, pop, full, empty and level outputs, parameterised by width and depth. Capture, address computation and the FSM stay in the top module.

## Test plan
- **Single changing tuple.** Reset; drive (x=10, y=2, c=1) with fb_ready=1 → one transfer, addr 1290 data 1, at the second edge after capture. A held tuple gives no further writes.
- **Off-screen filter.** Drive x=640 y=0, then x=0 y=480 → no fb_wr, fifo_level stays 0.
- **Backpressure and overflow.** fb_ready=0 with 20 distinct tuples → fifo_level=16, overflow=1, addr/data stable. Releasing fb_ready drains exactly 16 writes in order.
- **Clear.** clear_req with an empty FIFO → addresses 0…307199 all with data 0, clear_busy high throughout and low after the last transfer. The current drawer pixel is re-written afterwards.
- **Clear during a pending write.** fb_wr high, fb_ready=0, 3 entries queued, pulse clear_req → the held write completes first, the other 2 are discarded, and CLEAR starts at addr 0.
- **Reset mid-clear.** Assert reset at clear address 1000 → next cycle all outputs 0 and state IDLE.
